pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and jump-target width.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port instr_valid  input  1  instruction at pc_out is present and its control signals are valid this cycle.
REQ-005 SHALL have port stall  input  1  hold; the current instruction does not retire.
REQ-006 SHALL have ports is_jz, is_jnz, is_jg, is_jl, is_jump  input  1 each  decoded branch controls.
REQ-007 SHALL have port flags_write  input  1  decoded flag-update enable.
REQ-008 SHALL have ports alu_zero, alu_less  input  1 each  flag values produced by the retiring instruction.
REQ-009 SHALL have port jump_addr  input  PC_W  absolute branch target.
REQ-010 SHALL have port pc_out  output  PC_W  address of the instruction to fetch/execute.
REQ-011 SHALL have port flush  output  1  high while the unit is discarding the post-branch slot.
REQ-012 SHALL have port flags_out  output  3  registered {G,L,Z}.
REQ-013 SHALL have port retired_count  output  16  number of retired instructions.

Function
REQ-014 SHALL retire an instruction in a cycle where state=RUN, instr_valid=1, stall=0, rst=0.
REQ-015 SHALL, on retirement with flags_write=1, load Z=alu_zero, L=alu_less & ~alu_zero, G=~alu_zero & ~alu_less.
REQ-016 SHALL evaluate branch conditions using the flags register value before that cycle's update.
REQ-017 SHALL take a branch on retirement when: is_jump; or is_jz&Z; or is_jnz&~Z; or is_jg&G; or is_jl&L.
REQ-018 SHALL, when several branch controls are high at once, take the branch if any enabled condition holds; target is always jump_addr.
REQ-019 SHALL set pc_out to jump_addr on the edge after a taken branch, otherwise to pc_out+1 modulo 2^PC_W (0xFF wraps to 0x00 for PC_W=8).
REQ-020 SHALL keep pc_out, flags and retired_count unchanged in any cycle without retirement.
REQ-021 SHALL implement states RUN and FLUSH: RUN->FLUSH on a taken branch; FLUSH->RUN unconditionally after one cycle; otherwise remain in RUN.
REQ-022 SHALL drive flush=1 exactly while in FLUSH; instr_valid, stall and control inputs are ignored in FLUSH, and pc_out holds the branch target.
REQ-023 SHALL increment retired_count by 1 per retirement, saturating at 0xFFFF.
REQ-024 SHALL treat a not-taken branch as an ordinary retirement (pc+1, no FLUSH).
REQ-025 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, when rst=1 on a rising edge, set pc_out=0, flags_out=3'b000, retired_count=0, state=RUN, flush=0, overriding every other input including mid-FLUSH and stall.
REQ-027 SHALL perform no retirement in a cycle where rst=1.

Verification
REQ-028 SHALL be verified: reset, then 3 cycles instr_valid=1, no controls -> pc_out 0,1,2,3; retired_count=3; flush=0.
REQ-029 SHALL be verified: flags_write=1, alu_zero=1 retires, next cycle is_jz=1, jump_addr=0x40 -> flags_out=3'b001, pc_out=0x40, flush=1 for one cycle, then RUN.
REQ-030 SHALL be verified: same instruction carries flags_write=1, alu_zero=1 and is_jz=1 with Z previously 0 -> branch not taken (old flags), pc_out=pc+1, Z becomes 1.
REQ-031 SHALL be verified: pc_out=0xFF, retire non-branch -> pc_out=0x00; stall=1 for 2 cycles -> pc_out and retired_count unchanged.
REQ-032 SHALL be verified: is_jump taken, rst=1 during the FLUSH cycle -> next cycle pc_out=0, flush=0, flags_out=0, retired_count=0.
REQ-033 SHALL be verified: alu_less=1, flags_write=1 retires, then is_jg=1 (not taken, pc+1) then is_jl=1 jump_addr=0x10 (taken, pc_out=0x10).

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program counter with a flags register and conditional branch resolution.
// A taken branch redirects pc_out and inserts one FLUSH cycle that discards the post-branch slot.
module pc_branch_unit #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic            stall,
  input  logic            is_jz,
  input  logic            is_jnz,
  input  logic            is_jg,
  input  logic            is_jl,
  input  logic            is_jump,
  input  logic            flags_write,
  input  logic            alu_zero,
  input  logic            alu_less,
  input  logic [PC_W-1:0] jump_addr,
  output logic [PC_W-1:0] pc_out,
  output logic            flush,
  output logic [2:0]      flags_out,
  output logic [15:0]     retired_count,
  output logic            dbg_state
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic            retire;
  logic            taken;
  logic            flag_z;
  logic            flag_l;
  logic            flag_g;
  logic [PC_W-1:0] pc_d;
  logic [2:0]      flags_d;
  logic [15:0]     count_d;

  // flags_out is packed {G,L,Z}; branch conditions always use the pre-update value.
  assign flag_z = flags_out[0];
  assign flag_l = flags_out[1];
  assign flag_g = flags_out[2];

  assign dbg_state = (state_q == FLUSH);

  // Handshake: the instruction at pc_out retires when instr_valid=1 and stall=0
  // while in RUN; stall holds it in place. In FLUSH every input except rst is ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_out;
    flags_d = flags_out;
    count_d = retired_count;
    retire  = 1'b0;
    taken   = 1'b0;
    case (state_q)
      RUN: begin
        retire = instr_valid & ~stall;
        if (retire) begin
          taken = is_jump
                | (is_jz  &  flag_z)
                | (is_jnz & ~flag_z)
                | (is_jg  &  flag_g)
                | (is_jl  &  flag_l);
          if (flags_write) begin
            flags_d = {~alu_zero & ~alu_less, alu_less & ~alu_zero, alu_zero};
          end
          if (retired_count != 16'hFFFF) begin
            count_d = retired_count + 16'd1;
          end
          if (taken) begin
            pc_d    = jump_addr;
            state_d = FLUSH;
          end else begin
            pc_d    = pc_out + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_out        <= '0;
      flags_out     <= 3'b000;
      retired_count <= 16'd0;
      flush         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_out        <= pc_d;
      flags_out     <= flags_d;
      retired_count <= count_d;
      flush         <= (state_d == FLUSH);
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus a random run
// checked against a reference model through an expected-value queue.
module tb_pc_branch_unit;

  localparam int PC_W = 8;
  localparam int W    = PC_W + 3 + 16 + 1;

  // clock / reset
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic            instr_valid, stall;
  logic            is_jz, is_jnz, is_jg, is_jl, is_jump;
  logic            flags_write, alu_zero, alu_less;
  logic [PC_W-1:0] jump_addr;
  logic [PC_W-1:0] pc_out;
  logic            flush;
  logic [2:0]      flags_out;
  logic [15:0]     retired_count;
  logic            dbg_state;

  pc_branch_unit #(.PC_W(PC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .is_jz         (is_jz),
    .is_jnz        (is_jnz),
    .is_jg         (is_jg),
    .is_jl         (is_jl),
    .is_jump       (is_jump),
    .flags_write   (flags_write),
    .alu_zero      (alu_zero),
    .alu_less      (alu_less),
    .jump_addr     (jump_addr),
    .pc_out        (pc_out),
    .flush         (flush),
    .flags_out     (flags_out),
    .retired_count (retired_count),
    .dbg_state     (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] obs_v;
  assign obs_v = {pc_out, flags_out, retired_count, flush};

  // reference model
  logic [PC_W-1:0] m_pc;
  logic [2:0]      m_flags;
  logic [15:0]     m_cnt;
  logic            m_flush;

  task automatic model_step();
    logic tk;
    if (rst) begin
      m_pc = '0; m_flags = 3'b000; m_cnt = 16'd0; m_flush = 1'b0;
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (instr_valid && !stall) begin
      tk = is_jump | (is_jz & m_flags[0]) | (is_jnz & ~m_flags[0])
         | (is_jg & m_flags[2]) | (is_jl & m_flags[1]);
      if (flags_write) begin
        if (alu_zero)      m_flags = 3'b001;
        else if (alu_less) m_flags = 3'b010;
        else               m_flags = 3'b100;
      end
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_pc    = tk ? jump_addr : m_pc + 8'd1;
      m_flush = tk;
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic s, input logic [4:0] br,
                       input logic fw, input logic z, input logic l,
                       input logic [PC_W-1:0] a);
    instr_valid = v;  stall = s;
    {is_jump, is_jz, is_jnz, is_jg, is_jl} = br;
    flags_write = fw; alu_zero = z; alu_less = l; jump_addr = a;
  endtask

  task automatic tick();
    model_step();
    exp_q.push_back({m_pc, m_flags, m_cnt, m_flush});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    model_step();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [4:0] BR_JUMP = 5'b10000;
  localparam logic [4:0] BR_JZ   = 5'b01000;
  localparam logic [4:0] BR_JG   = 5'b00010;
  localparam logic [4:0] BR_JL   = 5'b00001;

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, BR_JUMP, 1'b1, 1'b1, 1'b0, 8'hAA);
    tick();
    rst = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL reset_sb got=%h exp=%h", obs_v, exp_v);
    end
    checks++;
    if (obs_v !== {8'h00, 3'b000, 16'd0, 1'b0}) begin
      failures++; $display("FAIL reset_vals got=%h exp=0", obs_v);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL seq_sb[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      checks++;
      if (pc_out !== 8'(i) || flush !== 1'b0) begin
        failures++; $display("FAIL seq_pc[%0d] got=%h/%b exp=%h/0", i, pc_out, flush, 8'(i));
      end
    end
    checks++;
    if (retired_count !== 16'd3) begin
      failures++; $display("FAIL seq_count got=%0d exp=3", retired_count);
    end
  endtask

  task automatic test_jz_taken();
    logic [PC_W-1:0] pcs[4]   = '{8'h01, 8'h40, 8'h40, 8'h41};
    logic            fls[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b1, 1'b0, 5'b0,    1'b1, 1'b1, 1'b0, 8'h00);
        1: drive(1'b1, 1'b0, BR_JZ,   1'b0, 1'b0, 1'b0, 8'h40);
        2: drive(1'b1, 1'b0, BR_JUMP, 1'b1, 1'b0, 1'b1, 8'h99); // ignored in FLUSH
        default: drive(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      endcase
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL jz_sb[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      checks++;
      if (pc_out !== pcs[i] || flush !== fls[i] || flags_out !== 3'b001) begin
        failures++;
        $display("FAIL jz_dir[%0d] got pc=%h fl=%b f=%b exp pc=%h fl=%b f=001",
                 i, pc_out, flush, flags_out, pcs[i], fls[i]);
      end
    end
  endtask

  task automatic test_same_cycle_flags();
    apply_reset();
    drive(1'b1, 1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_v !== exp_v || flags_out !== 3'b100) begin
      failures++; $display("FAIL same_pre got=%h exp=%h", obs_v, exp_v);
    end
    drive(1'b1, 1'b0, BR_JZ, 1'b1, 1'b1, 1'b0, 8'h20);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL same_sb got=%h exp=%h", obs_v, exp_v);
    end
    checks++;
    if (pc_out !== 8'h02 || flush !== 1'b0 || flags_out !== 3'b001) begin
      failures++;
      $display("FAIL same_dir got pc=%h fl=%b f=%b exp pc=02 fl=0 f=001", pc_out, flush, flags_out);
    end
  endtask

  task automatic test_wrap_stall();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1'b1, 1'b0, BR_JUMP, 1'b0, 1'b0, 1'b0, 8'hFF);
        1: drive(1'b0, 1'b0, 5'b0,    1'b0, 1'b0, 1'b0, 8'h00);
        2: drive(1'b1, 1'b0, 5'b0,    1'b0, 1'b0, 1'b0, 8'h00);
        default: drive(1'b1, 1'b1, BR_JUMP, 1'b1, 1'b1, 1'b0, 8'h77);
      endcase
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL wrap_sb[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
    end
    checks++;
    if (pc_out !== 8'h00 || retired_count !== 16'd2 || flags_out !== 3'b000) begin
      failures++;
      $display("FAIL wrap_stall got pc=%h cnt=%0d f=%b exp pc=00 cnt=2 f=000",
               pc_out, retired_count, flags_out);
    end
  endtask

  task automatic test_reset_in_flush();
    apply_reset();
    drive(1'b1, 1'b0, 5'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, BR_JUMP, 1'b0, 1'b0, 1'b0, 8'h55);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_v !== exp_v || flush !== 1'b1 || dbg_state !== 1'b1) begin
      failures++; $display("FAIL rif_pre got=%h st=%b exp=%h st=1", obs_v, dbg_state, exp_v);
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, BR_JUMP, 1'b1, 1'b0, 1'b1, 8'h33);
    tick();
    rst = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_v !== exp_v || obs_v !== '0 || dbg_state !== 1'b0) begin
      failures++; $display("FAIL rif_reset got=%h st=%b exp=0 st=0", obs_v, dbg_state);
    end
  endtask

  task automatic test_less_branches();
    logic [PC_W-1:0] pcs[3] = '{8'h01, 8'h02, 8'h10};
    logic            fls[3] = '{1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1'b1, 1'b0, 5'b0,  1'b1, 1'b0, 1'b1, 8'h00);
        1: drive(1'b1, 1'b0, BR_JG, 1'b0, 1'b0, 1'b0, 8'h30);
        default: drive(1'b1, 1'b0, BR_JL, 1'b0, 1'b0, 1'b0, 8'h10);
      endcase
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL less_sb[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      checks++;
      if (pc_out !== pcs[i] || flush !== fls[i] || flags_out !== 3'b010) begin
        failures++;
        $display("FAIL less_dir[%0d] got pc=%h fl=%b f=%b exp pc=%h fl=%b f=010",
                 i, pc_out, flush, flags_out, pcs[i], fls[i]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            5'($urandom_range(0, 31) & $urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL rand_sb[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    m_pc = '0; m_flags = '0; m_cnt = '0; m_flush = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_jz_taken();
    test_same_cycle_flags();
    test_wrap_stall();
    test_reset_in_flush();
    test_less_branches();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
